power_seq: RTL and testbench
============================

POWER_SEQ -- requirements
Module: power_seq

Interface
REQ-001 SHALL have ports: i_clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: i_srst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have ports: i_clkEn  input  1  clock enable; low freezes all state.
REQ-004 SHALL have ports: i_start  input  1  request pulse; sampled only in IDLE with i_clkEn high.
REQ-005 SHALL have ports: i_x  input  8  base operand, captured on accepted i_start.
REQ-006 SHALL have ports: i_n  input  4  exponent 0..15, captured on accepted i_start.
REQ-007 SHALL have ports: o_busy  output  1  high in every state except IDLE.
REQ-008 SHALL have ports: o_done  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports: o_result  output  8  x^n mod 256, valid from o_done onward.
REQ-010 SHALL have ports: o_overflow  output  1  present only with POWER_SEQ_OVERFLOW_EN.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, MUL, WAIT, DONE.
REQ-012 IDLE -> LOAD on i_start=1 (edge E); capture x, n; acc=1, cnt=n.
REQ-013 LOAD -> DONE if cnt=0, else -> MUL.
REQ-014 MUL: issue acc*x to registered multiplier; -> WAIT.
REQ-015 WAIT: acc=low 8 bits of product, cnt=cnt-1; -> DONE if new cnt=0, else -> MUL.
REQ-016 DONE: o_done=1 and o_result=acc for exactly one enabled cycle; -> IDLE.
REQ-017 Latency: DONE state entered at edge E+1+2n; n=0 gives E+1; n=15 gives E+31.
REQ-018 i_start outside IDLE SHALL be ignored, no queuing; operands ignored except at acceptance.
REQ-019 o_result SHALL hold last result until the next DONE; products truncate mod 256, no saturation.
REQ-020 i_clkEn=0 SHALL freeze FSM, acc, cnt, multiplier register and outputs, including o_done held high if in DONE.
REQ-021 IDLE with i_start=1 in the same cycle as DONE exit is not possible; start accepted earliest one cycle after o_done.

Reset
REQ-022 i_srst=1 SHALL override i_clkEn: state=IDLE, acc=1, cnt=0, o_busy=0, o_done=0, o_result=0, o_overflow=0.
REQ-023 Reset mid-operation SHALL abort without o_done; first post-reset start behaves as fresh.

Configuration
REQ-024 Macro POWER_SEQ_OVERFLOW_EN defined: o_overflow present; cleared on accepted start; set sticky when any product high byte nonzero; valid with o_done.
REQ-025 Macro undefined: o_overflow port and its logic absent; all other behaviour identical.

Structure
REQ-026 Package power_seq_pkg SHALL hold state enum type, DATA_W=8, EXP_W=4 constants.
REQ-027 Sub-module power_mul SHALL be the registered 8x8->16 multiplier with i_clk, i_clkEn, i_srst; one-cycle latency, reset value 0.

Verification
REQ-028 x=3, n=3, start at E -> o_done high after E+7, o_result=27, o_overflow=0.
REQ-029 x=2, n=0 -> o_done after E+1, o_result=1; x=0, n=0 -> o_result=1.
REQ-030 x=5, n=4 -> o_result=113; x=255, n=2 -> o_result=1, o_overflow=1 (macro on).
REQ-031 x=3, n=3 with i_clkEn low 4 cycles mid-run -> o_done after E+11, o_result=27; second i_start while busy ignored.
REQ-032 x=7, n=5, i_srst at E+4 -> no o_done, o_result=0, o_busy=0; then x=2, n=4 -> o_result=16 after 9 edges.

Source files
------------

// File: rtl/power_seq_pkg.sv
// Shared types and constants for the power sequencer.
// Holds the FSM state enum and the operand/exponent widths.

package power_seq_pkg;

  localparam int DATA_W = 8;
  localparam int EXP_W  = 4;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MUL  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/power_mul.sv
// Registered 8x8->16 multiplier, one-cycle latency.
// Ports: i_clk, i_srst (sync, active-high), i_clkEn (freeze),
//        i_a, i_b operands, o_p registered product (reset 0).

module power_mul
  import power_seq_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_srst,
  input  logic              i_clkEn,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [PROD_W-1:0] o_p
);

  logic [PROD_W-1:0] p_q;
  logic [PROD_W-1:0] p_d;

  assign p_d = PROD_W'(i_a) * PROD_W'(i_b);

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      p_q <= '0;
    end else if (i_clkEn) begin
      p_q <= p_d;
    end
  end

  assign o_p = p_q;

endmodule

// File: rtl/power_seq.sv
// Sequential x^n mod 256 by repeated multiplication.
// Ports: i_clk, i_srst (sync, active-high, overrides i_clkEn),
//   i_clkEn freeze, i_start/i_x/i_n request, o_busy, o_done
//   pulse, o_result (held), o_overflow (POWER_SEQ_OVERFLOW_EN).

module power_seq
  import power_seq_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_srst,
  input  logic              i_clkEn,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_x,
  input  logic [EXP_W-1:0]  i_n,
  output logic              o_busy,
  output logic              o_done,
`ifdef POWER_SEQ_OVERFLOW_EN
  output logic              o_overflow,
`endif
  output logic [DATA_W-1:0] o_result
);

  state_e            state_q;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;
  logic [EXP_W-1:0]  cnt_q;
  logic [EXP_W-1:0]  cnt_d;
  logic              done_q;
  logic [DATA_W-1:0] res_q;
  logic [PROD_W-1:0] prod;

  // Product register is free-running; WAIT consumes the
  // value captured on the MUL edge.
  power_mul u_mul (
    .i_clk   (i_clk),
    .i_srst  (i_srst),
    .i_clkEn (i_clkEn),
    .i_a     (acc_q),
    .i_b     (x_q),
    .o_p     (prod)
  );

  assign acc_d = prod[DATA_W-1:0];
  assign cnt_d = cnt_q - EXP_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      acc_q   <= DATA_W'(1);
      cnt_q   <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else if (i_clkEn) begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            x_q     <= i_x;
            acc_q   <= DATA_W'(1);
            cnt_q   <= i_n;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (cnt_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            res_q   <= acc_q;
          end else begin
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          if (cnt_d == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            res_q   <= acc_d;
          end else begin
            state_q <= S_MUL;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef POWER_SEQ_OVERFLOW_EN
  logic ovf_q;

  // Sticky across one operation, cleared when a start is taken.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      ovf_q <= 1'b0;
    end else if (i_clkEn) begin
      if (state_q == S_IDLE && i_start) begin
        ovf_q <= 1'b0;
      end else if (state_q == S_WAIT &&
                   prod[PROD_W-1:DATA_W] != '0) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign o_overflow = ovf_q;
`else
  logic unused_prod_hi;
  assign unused_prod_hi = ^prod[PROD_W-1:DATA_W];
`endif

  assign o_busy   = (state_q != S_IDLE);
  assign o_done   = done_q;
  assign o_result = res_q;

endmodule

// File: tb/tb_power_seq.sv
// Self-checking bench for power_seq: vector table, hand
// sequences for stall/reset, and randomized model checks.

module tb_power_seq;

  logic       clk = 1'b0;
  logic       srst;
  logic       clkEn;
  logic       start;
  logic [7:0] x;
  logic [3:0] n;
  logic       busy;
  logic       done;
  logic [7:0] res;
`ifdef POWER_SEQ_OVERFLOW_EN
  logic       ovf;
`endif

  always #5 clk = ~clk;

  power_seq dut (
    .i_clk      (clk),
    .i_srst     (srst),
    .i_clkEn    (clkEn),
    .i_start    (start),
    .i_x        (x),
    .i_n        (n),
    .o_busy     (busy),
    .o_done     (done),
`ifdef POWER_SEQ_OVERFLOW_EN
    .o_overflow (ovf),
`endif
    .o_result   (res)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] vx;
    logic [3:0] vn;
    logic [7:0] eres;
    int         elat;
    bit         eovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: x^n mod 256 as a sequence of truncated products;
  // overflow if any true product exceeds one byte.
  function automatic void ref_pow(input logic [7:0] bx,
                                  input logic [3:0] bn,
                                  output logic [7:0] r,
                                  output bit of);
    int acc;
    int p;
    acc = 1;
    of  = 0;
    for (int i = 0; i < int'(bn); i++) begin
      p = acc * int'(bx);
      if (p > 255) of = 1;
      acc = p % 256;
    end
    r = acc[7:0];
  endfunction

  // Runs one operation. Edges are counted after the accepting
  // edge E; clkEn is forced low on edges [st_from, st_from+st_len)
  // and otherwise high with probability pct.
  task automatic do_op(input logic [7:0] ox, input logic [3:0] on,
                       input int pct, input int st_from,
                       input int st_len, input bit poke,
                       output int en_e, output int all_e,
                       output logic [7:0] r, output logic of,
                       output bit got);
    int k;
    @(negedge clk);
    start = 1'b1;
    x     = ox;
    n     = on;
    clkEn = 1'b1;
    @(posedge clk);
    #1;
    check("busy_after_start", busy, 1);
    en_e  = 0;
    all_e = 0;
    got   = 0;
    r     = '0;
    of    = 1'b0;
    while (!got && all_e < 400) begin
      k = all_e + 1;
      if (k >= st_from && k < st_from + st_len) clkEn = 1'b0;
      else clkEn = ($urandom_range(99) < pct);
      start = poke ? 1'($urandom_range(1)) : 1'b0;
      x = 8'($urandom);
      n = 4'($urandom);
      @(posedge clk);
      all_e++;
      if (clkEn) en_e++;
      #1;
      if (done) got = 1;
    end
    start = 1'b0;
    if (!got) begin
      check("done_timeout", 0, 1);
      return;
    end
    r = res;
`ifdef POWER_SEQ_OVERFLOW_EN
    of = ovf;
`endif
    clkEn = 1'b0;
    @(posedge clk);
    #1;
    check("done_held_frozen", done, 1);
    clkEn = 1'b1;
    @(posedge clk);
    #1;
    check("done_one_cycle", {busy, done}, 0);
    check("result_held", res, r);
  endtask

  int         en_e;
  int         all_e;
  logic [7:0] r;
  logic       of;
  bit         got;
  logic [7:0] mr;
  bit         mof;
  int         seen;

  initial begin
    vecs[0] = '{8'd3,   4'd3,  8'd27,  7,  1'b0};
    vecs[1] = '{8'd2,   4'd0,  8'd1,   1,  1'b0};
    vecs[2] = '{8'd0,   4'd0,  8'd1,   1,  1'b0};
    vecs[3] = '{8'd5,   4'd4,  8'd113, 9,  1'b1};
    vecs[4] = '{8'd255, 4'd2,  8'd1,   5,  1'b1};
    vecs[5] = '{8'd2,   4'd8,  8'd0,   17, 1'b1};
    vecs[6] = '{8'd1,   4'd15, 8'd1,   31, 1'b0};
    vecs[7] = '{8'd3,   4'd15, 8'd107, 31, 1'b1};
    vecs[8] = '{8'd16,  4'd2,  8'd0,   5,  1'b1};
    vecs[9] = '{8'd0,   4'd5,  8'd0,   11, 1'b0};

    srst  = 1'b1;
    clkEn = 1'b0;
    start = 1'b0;
    x     = '0;
    n     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", res, 0);

    @(negedge clk);
    srst  = 1'b0;
    start = 1'b1;
    x     = 8'd9;
    n     = 4'd2;
    @(posedge clk);
    #1;
    check("start_gated_by_clken", busy, 0);
    @(negedge clk);
    start = 1'b0;
    clkEn = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].vx, vecs[i].vn, 100, 0, 0, 1'b1,
            en_e, all_e, r, of, got);
      check($sformatf("vec%0d_result", i), r, vecs[i].eres);
      check($sformatf("vec%0d_latency", i), all_e, vecs[i].elat);
`ifdef POWER_SEQ_OVERFLOW_EN
      check($sformatf("vec%0d_ovf", i), of, vecs[i].eovf);
`endif
    end

    do_op(8'd3, 4'd3, 100, 3, 4, 1'b1, en_e, all_e, r, of, got);
    check("stall_result", r, 27);
    check("stall_latency", all_e, 11);

    @(negedge clk);
    start = 1'b1;
    x     = 8'd7;
    n     = 4'd5;
    clkEn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    srst  = 1'b1;
    clkEn = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", res, 0);
    srst  = 1'b0;
    clkEn = 1'b1;
    seen  = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("abort_no_done", seen, 0);
    do_op(8'd2, 4'd4, 100, 0, 0, 1'b0, en_e, all_e, r, of, got);
    check("post_reset_result", r, 16);
    check("post_reset_latency", all_e, 9);

    for (int i = 0; i < 30; i++) begin
      logic [7:0] rx;
      logic [3:0] rn;
      rx = 8'($urandom);
      rn = 4'($urandom_range(15));
      ref_pow(rx, rn, mr, mof);
      do_op(rx, rn, 70, 0, 0, 1'b1, en_e, all_e, r, of, got);
      check($sformatf("rand%0d_result", i), r, mr);
      check($sformatf("rand%0d_en_edges", i), en_e,
            1 + 2 * int'(rn));
`ifdef POWER_SEQ_OVERFLOW_EN
      check($sformatf("rand%0d_ovf", i), of, mof);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
